// File: rtl/serial_adder_nand.sv
// Bit-serial WIDTH-bit adder with a start/done handshake, LSB first.
// Each bit uses two NAND half-adder stages plus a NAND carry-merge gate.
module serial_adder_nand #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;

  logic n1, p, n2, s, c;

  // n1/n2 are the inverted half-adder carries; NAND of them merges the carry.
  always_comb begin
    n1 = ~(a_sh_q[0] & b_sh_q[0]);
    p  = ~(~(a_sh_q[0] & n1) & ~(b_sh_q[0] & n1));
    n2 = ~(p & carry_q);
    s  = ~(~(p & n2) & ~(carry_q & n2));
    c  = ~(n1 & n2);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = ADD;
        end else begin
          state_d  = IDLE;
        end
      end
      ADD: begin
        sum_sh_d = {s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          // Result registers load together with entering DONE and then hold.
          sum_d   = {s, sum_sh_q[WIDTH-1:1]};
          cout_d  = c;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_nand.sv
// Directed bench for serial_adder_nand: 8-bit and 4-bit instances, queue scoreboard.
module tb_serial_adder_nand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder_nand #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_nand #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] sb8[$];
  logic [4:0] sb4[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    sb8.push_back({1'b0, av} + {1'b0, bv});
    #1 start8 = 1'b0;
  endtask

  task automatic wait8(input int n0, output int n, output int nb);
    n = n0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
    end while (!done8 && n < 40);
  endtask

  task automatic check8(input string tag);
    logic [8:0] exp;
    chk({tag, "_sbq"}, 16'(sb8.size() > 0), 16'd1);
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1FF;
    chk(tag, 16'({cout8, sum8}), 16'(exp));
  endtask

  task automatic start_op4(input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(posedge clk);
    sb4.push_back({1'b0, av} + {1'b0, bv});
    #1 start4 = 1'b0;
  endtask

  task automatic wait4(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done4 && n < 30);
  endtask

  task automatic check4(input string tag);
    logic [4:0] exp;
    exp = (sb4.size() > 0) ? sb4.pop_front() : 5'h1F;
    chk(tag, 16'({cout4, sum4}), 16'(exp));
  endtask

  initial begin
    int n, nb;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(busy8), 16'd0);
    chk("rst_done", 16'(done8), 16'd0);
    chk("rst_res", 16'({cout8, sum8}), 16'd0);
    rst = 1'b0;

    start_op8(8'h00, 8'h00);
    wait8(0, n, nb);
    chk("zero_lat", 16'(n), 16'd9);
    chk("zero_busy", 16'(nb), 16'd8);
    check8("zero_res");
    @(negedge clk);
    chk("done_pulse", 16'(done8), 16'd0);

    start_op8(8'hFF, 8'h01);
    wait8(0, n, nb);
    chk("ff01_lat", 16'(n), 16'd9);
    check8("ff01_res");
    start_op8(8'hA5, 8'h5A);
    wait8(0, n, nb);
    check8("a55a_res");
    repeat (5) @(negedge clk);
    chk("hold_res", 16'({cout8, sum8}), 16'h0FF);
    chk("hold_busy", 16'(busy8), 16'd0);

    // start held high: next op accepted in each DONE cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    sb8.push_back(9'h1FE);
    for (int k = 0; k < 3; k++) begin
      wait8(0, n, nb);
      chk("btb_lat", 16'(n), 16'd9);
      check8("btb_res");
      if (k < 2) begin
        @(posedge clk);
        sb8.push_back(9'h1FE);
      end else begin
        start8 = 1'b0;
      end
    end

    start_op8(8'h3C, 8'h0F);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(3, n, nb);
    chk("ign_lat", 16'(n), 16'd9);
    check8("ign_res");

    start_op8(8'h80, 8'h80);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 16'(busy8), 16'd0);
    chk("abort_done", 16'(done8), 16'd0);
    chk("abort_res", 16'({cout8, sum8}), 16'd0);
    rst = 1'b0;
    sb8.delete();
    sb4.delete();
    start_op8(8'h80, 8'h80);
    wait8(0, n, nb);
    chk("after_abort_lat", 16'(n), 16'd9);
    check8("after_abort_res");

    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      start_op4(iv[3:0], iv[7:4]);
      wait4(n);
      chk("w4_lat", 16'(n), 16'd5);
      check4("w4_res");
    end

    @(negedge clk);
    a4 = 'x; b4 = 4'h0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait4(n);
    chk("x_lat", 16'(n), 16'd5);
    start_op4(4'h9, 4'h9);
    wait4(n);
    chk("x_recover_lat", 16'(n), 16'd5);
    check4("x_recover_res");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_nand.md
Name: serial_adder_nand

Overview:
- Bit-serial N-bit adder built around the team's NAND-gate half-adder cell. Two half-adder stages plus a carry-merge gate form the per-bit full adder.
- Sits directly downstream of the half-adder cell. It consumes the cell's sum/carry outputs each clock, registers the carry and accumulates the sum bits into a parallel result.
- Start/done handshake. One operand pair is processed per operation, LSB first.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled each rising edge.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- busy  output  1  high while the ADD state is active.
- done  output  1  single-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result bits [WIDTH-1:0].
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a rising edge): the following are cleared to 0:
  - state to IDLE
  - shift registers a_sh, b_sh, sum_sh
  - carry register, counter
  - busy, done, sum, cout
- rst has priority over every other input. Reset during ADD aborts the operation; the partial sum is discarded.
- FSM states: IDLE, ADD, DONE. Two-process or single-process implementation is acceptable; outputs must be registered or decoded from state only. No combinational path from inputs to outputs.
- IDLE:
  - If start=1: load a_sh<=a, b_sh<=b, carry<=0, cnt<=0, sum_sh<=0, and go to ADD.
  - Otherwise stay in IDLE.
- ADD, on each edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry, computed via two half-adder stages.
  - c = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&carry).
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; carry <= c; cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge, go to DONE.
- DONE (lasts exactly one cycle):
  - done=1; sum drives sum_sh; cout drives carry.
  - If start=1: accept a new operation exactly as in IDLE (load, go to ADD). Otherwise go to IDLE.
- Output hold: sum and cout hold their last values in IDLE until the next accepted start. On the accept edge they are not cleared; they update only when the next DONE is entered.
- Latency: start accepted at edge E0 → busy=1 after E0 → DONE entered at edge E_WIDTH → done=1 during the cycle after E_WIDTH. For WIDTH=8, done is high in the 9th cycle after the accepting edge.
- Throughput: WIDTH+1 cycles per operation with start held high.
- start during ADD is ignored (not queued). a and b may change freely after the accepting edge without affecting the result.
- Arithmetic: unsigned modulo 2**WIDTH. {cout,sum} = a+b exactly.
- X handling: X on a or b at the accept edge propagates to sum/cout. No scrubbing is performed. X on start while in IDLE or DONE is a bench error.
- The counter never wraps in normal operation; it is reset to 0 on each accept.

Test Plan:
- Reset then a=8'h00, b=8'h00, start pulse → busy high for 8 cycles, done pulse in 9th cycle, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A → sum=8'hFF, cout=0. Sum/cout stable in IDLE afterwards.
- a=8'hFF, b=8'hFF, with start held high continuously → result sum=8'hFE, cout=1. Second operation starts in the DONE cycle; done pulses every 9 cycles.
- Start accepted with a=8'h3C, b=8'h0F. Change a/b to 8'hFF and pulse start during ADD → start ignored; result is sum=8'h4B, cout=0 at the original latency.
- rst asserted on the 4th ADD cycle of 8'h80+8'h80 → next cycle busy=0, done=0, sum=0, cout=0. A new start with 8'h80+8'h80 completes with sum=8'h00, cout=1.
- Exhaustive sweep with WIDTH=4 over all 256 operand pairs → every {cout,sum} equals a+b. Also apply a=4'bxxxx, b=4'h0 → sum shows X, with no hang of the FSM.
